// File: rtl/pc_seq_pkg.sv
// Package: pc_seq_pkg
// Shared definitions for the program-counter sequencer, the decoder and the
// EX/MA pipeline register: the next-PC selector encoding, the branch/jump
// take-condition helper and default address constants.
package pc_seq_pkg;

    // Next-PC selector as carried through EX/MA.
    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BLT  = 3'd1,
        SEL_BEQ  = 3'd2,
        SEL_JAL  = 3'd3,
        SEL_JALR = 3'd4,
        SEL_BNE  = 3'd5,
        SEL_BGE  = 3'd6,
        SEL_TRAP = 3'd7
    } sel_e;

    localparam int unsigned DEFAULT_XLEN         = 32;
    localparam int unsigned DEFAULT_RESET_VECTOR = 0;
    localparam int unsigned DEFAULT_INSTR_BYTES  = 4;

    // Whether the selected control transfer is taken, given the EX compare flags.
    function automatic logic take_cond(input sel_e sel, input logic less, input logic zero);
        logic take;
        case (sel)
            SEL_SEQ:  take = 1'b0;
            SEL_BLT:  take = less;
            SEL_BEQ:  take = zero;
            SEL_BNE:  take = ~zero;
            SEL_BGE:  take = ~less;
            default:  take = 1'b1;  // JAL, JALR, TRAP are unconditional
        endcase
        return take;
    endfunction

endpackage

// File: rtl/pc_flush_shadow.sv
// Module: pc_flush_shadow
// Loadable down-counter that keeps the wrong-path flush asserted for DEPTH
// cycles after a redirect. It counts down every edge, independent of stalls.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   load   in   redirect taken this cycle: reload counter with DEPTH
//   flush  out  registered, high while the counter is non-zero
module pc_flush_shadow #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic flush
);

    localparam int unsigned CW = 3;  // holds DEPTH up to 7

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (load)
            cnt_next = CW'(DEPTH);
        else if (cnt != '0)
            cnt_next = cnt - CW'(1);
    end

    // flush is registered from the next count so it is glitch-free at the boundary.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            flush <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            flush <= (cnt_next != '0);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Program-counter unit: owns the PC register and resolves the next fetch
// address from EX/MA branch/jump information, with a flush shadow after each
// redirect, target alignment trapping and a saturating taken-redirect counter.
// Ports:
//   ClkIn, RstIn        clock (rising) and asynchronous active-high reset
//   StallIn             hold PC (a redirect still wins)
//   ValidIn             EX/MA selector and targets are valid
//   SelectorIn          next-PC mode (see pc_seq_pkg::sel_e)
//   LessIn, ZeroIn      rs1<rs2, rs1==rs2
//   PCRelAddrIn         PC-relative target
//   RegRelAddrIn        register-relative target (bit 0 cleared)
//   TrapVecIn           trap handler base (already aligned)
//   PCOut               current fetch address
//   SeqAddrOut          PCOut + INSTR_BYTES
//   RedirectOut         combinational: redirect taken this cycle
//   FlushOut            registered: kill wrong-path stages
//   MisalignOut         registered one-cycle pulse after a misaligned redirect
//   TakenCntOut         saturating count of redirects since reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned          XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int unsigned          INSTR_BYTES  = DEFAULT_INSTR_BYTES,
    parameter int unsigned          FLUSH_DEPTH  = 2,
    parameter int unsigned          CNT_W        = 16
) (
    input  logic              ClkIn,
    input  logic              RstIn,
    input  logic              StallIn,
    input  logic              ValidIn,
    input  logic [2:0]        SelectorIn,
    input  logic              LessIn,
    input  logic              ZeroIn,
    input  logic [XLEN-1:0]   PCRelAddrIn,
    input  logic [XLEN-1:0]   RegRelAddrIn,
    input  logic [XLEN-1:0]   TrapVecIn,
    output logic [XLEN-1:0]   PCOut,
    output logic [XLEN-1:0]   SeqAddrOut,
    output logic              RedirectOut,
    output logic              FlushOut,
    output logic              MisalignOut,
    output logic [CNT_W-1:0]  TakenCntOut
);

    localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0]  STEP       = XLEN'(INSTR_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    sel_e            sel;
    logic            accept;
    logic            take;
    logic            misalign;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_next;

    assign sel        = sel_e'(SelectorIn);
    // Requests inside the flush shadow come from wrong-path instructions.
    assign accept     = ValidIn & ~FlushOut;
    assign take       = take_cond(sel, LessIn, ZeroIn);
    assign RedirectOut = accept & take;
    assign SeqAddrOut = PCOut + STEP;  // wraps modulo 2^XLEN

    always_comb begin
        raw_target = PCRelAddrIn;
        case (sel)
            SEL_JALR: raw_target = RegRelAddrIn & ~XLEN'(1);
            SEL_TRAP: raw_target = TrapVecIn;
            default:  raw_target = PCRelAddrIn;
        endcase
    end

    // The trap vector is aligned by integration, so TRAP is never flagged.
    assign misalign = (sel != SEL_TRAP) && ((raw_target & ALIGN_MASK) != '0);
    assign target   = misalign ? TrapVecIn : raw_target;

    always_comb begin
        pc_next = SeqAddrOut;
        if (RedirectOut)
            pc_next = target;
        else if (StallIn)
            pc_next = PCOut;
    end

    always_ff @(posedge ClkIn or posedge RstIn) begin
        if (RstIn) begin
            PCOut       <= RESET_VECTOR;
            MisalignOut <= 1'b0;
            TakenCntOut <= '0;
        end else begin
            PCOut       <= pc_next;
            MisalignOut <= RedirectOut & misalign;
            if (RedirectOut && (TakenCntOut != CNT_MAX))
                TakenCntOut <= TakenCntOut + CNT_W'(1);
        end
    end

    pc_flush_shadow #(
        .DEPTH (FLUSH_DEPTH)
    ) u_flush_shadow (
        .clk   (ClkIn),
        .rst   (RstIn),
        .load  (RedirectOut),
        .flush (FlushOut)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench: tb_pc_sequencer
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the PC sequencer kept in this file.
module tb_pc_sequencer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IB    = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;
    localparam int          CMAX  = (1 << CW) - 1;

    logic            ClkIn = 1'b0;
    logic            RstIn;
    logic            StallIn;
    logic            ValidIn;
    logic [2:0]      SelectorIn;
    logic            LessIn;
    logic            ZeroIn;
    logic [XLEN-1:0] PCRelAddrIn;
    logic [XLEN-1:0] RegRelAddrIn;
    logic [XLEN-1:0] TrapVecIn;
    logic [XLEN-1:0] PCOut;
    logic [XLEN-1:0] SeqAddrOut;
    logic            RedirectOut;
    logic            FlushOut;
    logic            MisalignOut;
    logic [CW-1:0]   TakenCntOut;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [31:0] m_pc;
    int          m_flush_left;
    int          m_cnt;
    bit          m_mis;

    pc_sequencer #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0),
        .INSTR_BYTES  (IB),
        .FLUSH_DEPTH  (DEPTH),
        .CNT_W        (CW)
    ) dut (
        .ClkIn        (ClkIn),
        .RstIn        (RstIn),
        .StallIn      (StallIn),
        .ValidIn      (ValidIn),
        .SelectorIn   (SelectorIn),
        .LessIn       (LessIn),
        .ZeroIn       (ZeroIn),
        .PCRelAddrIn  (PCRelAddrIn),
        .RegRelAddrIn (RegRelAddrIn),
        .TrapVecIn    (TrapVecIn),
        .PCOut        (PCOut),
        .SeqAddrOut   (SeqAddrOut),
        .RedirectOut  (RedirectOut),
        .FlushOut     (FlushOut),
        .MisalignOut  (MisalignOut),
        .TakenCntOut  (TakenCntOut)
    );

    always #5 ClkIn = ~ClkIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc         = 32'h0;
        m_flush_left = 0;
        m_cnt        = 0;
        m_mis        = 1'b0;
    endtask

    task automatic check_regs(input string phase);
        check({phase, "_pc"},    PCOut,       m_pc);
        check({phase, "_flush"}, FlushOut,    32'(m_flush_left != 0));
        check({phase, "_mis"},   MisalignOut, 32'(m_mis));
        check({phase, "_cnt"},   TakenCntOut, 32'(m_cnt));
    endtask

    // One clock cycle: drive inputs just after an edge, check combinational
    // outputs mid-cycle, advance the model across the edge, check registers.
    task automatic step(input bit valid, input int sel, input bit less, input bit zero,
                        input bit stall, input logic [31:0] pcrel, input logic [31:0] regrel,
                        input logic [31:0] trapv);
        bit          accept, take, redir, mis;
        logic [31:0] tgt;
        ValidIn      = valid;
        SelectorIn   = 3'(sel);
        LessIn       = less;
        ZeroIn       = zero;
        StallIn      = stall;
        PCRelAddrIn  = pcrel;
        RegRelAddrIn = regrel;
        TrapVecIn    = trapv;
        #1;
        accept = valid && (m_flush_left == 0);
        case (sel)
            0:       take = 1'b0;
            1:       take = less;
            2:       take = zero;
            5:       take = !zero;
            6:       take = !less;
            default: take = 1'b1;
        endcase
        if (sel == 4)      tgt = {regrel[31:1], 1'b0};
        else if (sel == 7) tgt = trapv;
        else               tgt = pcrel;
        mis = (sel != 7) && ((tgt % IB) != 0);
        if (mis) tgt = trapv;
        redir = accept && take;
        check("redirect", RedirectOut, 32'(redir));
        check("seq_addr", SeqAddrOut, m_pc + IB);
        @(posedge ClkIn);
        if (redir)      m_pc = tgt;
        else if (!stall) m_pc = m_pc + IB;
        m_flush_left = redir ? DEPTH : (m_flush_left > 0 ? m_flush_left - 1 : 0);
        m_mis        = redir && mis;
        if (redir && m_cnt < CMAX) m_cnt++;
        #1;
        check_regs("step");
    endtask

    task automatic idle(input bit stall);
        step(1'b0, 0, 1'b0, 1'b0, stall, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        RstIn = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge ClkIn);
        #1;
        check_regs("reset");
        RstIn = 1'b0;

        // Free running from the reset vector.
        idle(1'b0); check("free_pc4", PCOut, 32'h4);
        idle(1'b0); check("free_pc8", PCOut, 32'h8);
        idle(1'b0); check("free_pcC", PCOut, 32'hC);
        repeat (5) idle(1'b0);
        check("at_0x20", PCOut, 32'h20);

        // BEQ taken under stall: redirect wins, two-cycle shadow.
        step(1'b1, 2, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 32'h0);
        check("beq_pc", PCOut, 32'h100);
        check("beq_cnt", TakenCntOut, 32'h1);
        idle(1'b0);
        idle(1'b0);
        check("shadow_end", FlushOut, 32'h0);
        // BNE with equal operands is not taken.
        step(1'b1, 5, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);

        // JAL, then JALR attempts inside the shadow are ignored.
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h301, 32'h0);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h301, 32'h0);
        check("jalr_ignored", PCOut, 32'h208);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h301, 32'h0);
        check("jalr_pc", PCOut, 32'h300);
        idle(1'b0); idle(1'b0);

        // Misaligned BGE target traps to the vector.
        step(1'b1, 6, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0, 32'h80);
        check("bge_trap_pc", PCOut, 32'h80);
        check("bge_mis", MisalignOut, 32'h1);
        idle(1'b0);
        check("mis_pulse_end", MisalignOut, 32'h0);
        idle(1'b0);

        // Fifth redirect: counter stays saturated; then wrap at the top of memory.
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
        check("cnt_sat", TakenCntOut, 32'h3);
        idle(1'b1); idle(1'b1);
        check("held_top", PCOut, 32'hFFFF_FFFC);
        idle(1'b0);
        check("wrap_pc", PCOut, 32'h0);

        // Asynchronous reset between edges inside a shadow.
        step(1'b1, 7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40);
        #2 RstIn = 1'b1;
        #1;
        model_reset();
        check_regs("async_rst");
        @(posedge ClkIn);
        #1;
        check_regs("rst_held");
        RstIn = 1'b0;
        idle(1'b0);
        check("post_rst_pc", PCOut, 32'h4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pr, rr, tv;
            pr = $urandom;
            rr = $urandom;
            tv = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) pr = pr & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) rr = rr & 32'hFFFF_FFFD;
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), pr, rr, tv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    task automatic idle_inputs();
        StallIn      = 1'b0;
        ValidIn      = 1'b0;
        SelectorIn   = 3'd0;
        LessIn       = 1'b0;
        ZeroIn       = 1'b0;
        PCRelAddrIn  = '0;
        RegRelAddrIn = '0;
        TrapVecIn    = '0;
    endtask

endmodule
